// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU ops, opcodes,
// funct codes, operand/PC select values and the controller state enumeration.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_SLL = 3'd0,
    ALU_OR  = 3'd1,
    ALU_SRL = 3'd2,
    ALU_AND = 3'd3,
    ALU_ADD = 3'd4,
    ALU_NOR = 3'd5,
    ALU_SUB = 3'd6
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_REG   = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;

  localparam logic [1:0] SRC_B_REG    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_IMMEX,
    S_IMMWB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_op_decoder.sv
// R-type funct decoder: selects the ALU operation, flags shifts (which take
// shamt as operand A) and reports whether the funct is supported.
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       shift_sel,
  output logic       valid
);

  always_comb begin
    alu_op    = ALU_ADD;
    shift_sel = 1'b0;
    valid     = 1'b1;
    case (funct)
      FN_ADD: alu_op = ALU_ADD;
      FN_SUB: alu_op = ALU_SUB;
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_NOR: alu_op = ALU_NOR;
      FN_SLL: begin
        alu_op    = ALU_SLL;
        shift_sel = 1'b1;
      end
      FN_SRL: begin
        alu_op    = ALU_SRL;
        shift_sel = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with memory wait-timeout.
// Define ILLEGAL_TRAP_EN to make illegal instructions lock the FSM in TRAP.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       bus_err,
  output logic       illegal,
  output state_t     dbg_state
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  alu_op_t             dec_op;
  logic                dec_shift, dec_valid;
  logic                wait_state, timeout;

  alu_op_decoder u_alu_op_decoder (
    .funct     (funct),
    .alu_op    (dec_op),
    .shift_sel (dec_shift),
    .valid     (dec_valid)
  );

  // Memory handshake: a request in FETCH/MEMRD/MEMWR is held until the cycle
  // mem_ready is high, which completes it; mem_ready is ignored elsewhere.
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout    = wait_state && !mem_ready && (cnt_q == WAIT_W'(MAX_WAIT));
  assign dbg_state  = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    alu_op     = ALU_ADD;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    ext_zero   = 1'b0;
    pc_src     = PC_SRC_ALU;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    bus_err    = 1'b0;
    illegal    = 1'b0;

    // Counter is zero on every entry to a wait state because all other
    // states and every completion/timeout leave it cleared.
    if (wait_state && !mem_ready && !timeout) cnt_d = cnt_q + WAIT_W'(1);

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRC_B_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = S_EXEC;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = ILL_NEXT;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_op    = dec_op;
        alu_src_a = dec_shift ? SRC_A_SHAMT : SRC_A_REG;
        if (dec_valid) begin
          state_d = S_ALUWB;
        end else begin
          illegal = 1'b1;
          state_d = ILL_NEXT;
        end
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_ANDI: begin
            alu_op   = ALU_AND;
            ext_zero = 1'b1;
          end
          OP_ORI: begin
            alu_op   = ALU_OR;
            ext_zero = 1'b1;
          end
          default: alu_op = ALU_ADD;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_op    = ALU_SUB;
        alu_src_a = SRC_A_REG;
        pc_src    = PC_SRC_ALUOUT;
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PC_SRC_JUMP;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase

    if (timeout) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      bus_err   = 1'b1;
      state_d   = S_FETCH;
    end

    // Nothing may take effect while reset is held, even combinationally.
    if (reset) begin
      pc_en     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      bus_err   = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS main control FSM. It is the initiator side of the ALU command interface: it sequences each instruction and drives alu_op, the operand selects and all datapath enables.
- Consumes opcode/funct from the instruction register and the ALU's zero flag.
- Handshakes with the memory port through mem_ready and a wait-timeout counter.

Parameters:
- MAX_WAIT, 255, cycles a memory state may wait for mem_ready before bus_err; range 1..255.
- WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- alu_op  out  3  0 SLL, 1 OR, 2 SRL, 3 AND, 4 ADD, 5 NOR, 6 SUB
- alu_src_a  out  2  0 PC, 1 regA, 2 shamt (zero-extended instr[10:6])
- alu_src_b  out  2  0 regB, 1 const 4, 2 extended imm, 3 extended imm<<2
- ext_zero  out  1  1 zero-extend imm, 0 sign-extend
- pc_src  out  2  0 ALU result, 1 ALUOut, 2 jump target
- pc_en  out  1  PC load
- iord  out  1  0 instruction address, 1 ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  1 rd, 0 rt
- mem_to_reg  out  1  1 MDR, 0 ALUOut
- reg_write  out  1  register file write
- bus_err  out  1  one-cycle pulse on memory timeout
- illegal  out  1  unsupported opcode/funct detected

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP.
- Reset: state=FETCH, wait counter=0, illegal=0, bus_err=0. All enables stay 0 while reset is high.
- Reset mid-instruction aborts immediately; no partial write completes.
- Outputs are Moore decode of state, with these exceptions:
  - FETCH: ir_write and pc_en are gated by mem_ready.
  - BRANCH: pc_en is gated by zero.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=1, ADD, pc_src=0. Holds until mem_ready, then DECODE.
- DECODE: ADD of PC + (sext imm<<2) into ALUOut. Next state by opcode:
  - 0x23/0x2B -> MEMADR
  - 0x00 -> EXEC
  - 0x08/0x0C/0x0D -> IMMEX
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP
  - anything else -> illegal path
- MEMADR: regA + sext imm, ADD. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Waits for mem_ready, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: iord=1, mem_write=1 held until mem_ready, then FETCH.
- EXEC: alu_op from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x00 SLL, 0x02 SRL.
  - Shifts use alu_src_a=2, alu_src_b=0; all others use alu_src_a=1, alu_src_b=0.
  - Unsupported funct takes the illegal path.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- IMMEX: alu_src_a=1, alu_src_b=2.
  - addi: ADD, ext_zero=0.
  - andi: AND, ext_zero=1.
  - ori: OR, ext_zero=1.
- IMMWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- BRANCH: regA vs regB with SUB, pc_src=1. pc_en = zero for beq (0x04), ~zero for bne (0x05). Then FETCH.
- JUMP: pc_src=2, pc_en=1, then FETCH.
- Latency with zero-wait memory: R-type 4, imm 4, lw 5, sw 4, branch 3, jump 3 cycles.
- Wait counter:
  - Clears on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle in those states while mem_ready=0.
  - When the counter equals MAX_WAIT with mem_ready still 0: bus_err=1 for one cycle, no enables asserted, next state FETCH.
- mem_ready in the same cycle as the timeout wins: normal completion, no bus_err.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: the illegal path enters terminal state TRAP. illegal=1 and stays sticky; all enables are 0; only reset exits.
- Undefined: the illegal path pulses illegal for one cycle and returns to FETCH. The instruction is a NOP and the PC has already advanced.

Decomposition:
- Package mips_ctrl_pkg holds:
  - alu_op constants (values 0..6 above)
  - opcode and funct constants
  - src-select encodings
  - the state enumeration
- Sub-module alu_op_decoder: combinational funct -> {alu_op, shift_sel, valid}, instantiated for the EXEC state.

Test Plan:
- add (op 0x00, funct 0x20), mem_ready=1 every cycle -> states FETCH, DECODE, EXEC, ALUWB. EXEC alu_op=4; ALUWB reg_write=1 with reg_dst=1; total 4 cycles.
- sll (funct 0x00) -> EXEC alu_op=0, alu_src_a=2, alu_src_b=0. srl (funct 0x02) -> alu_op=2.
- lw (0x23) with mem_ready low 3 cycles in MEMRD -> mem_read and iord held 3 cycles. MEMWB one cycle later: reg_write=1, mem_to_reg=1; no bus_err.
- beq (0x04) zero=1 -> pc_en=1, pc_src=1 in BRANCH. bne (0x05) zero=1 -> pc_en=0.
- Fetch with mem_ready held 0 and MAX_WAIT=4 -> bus_err pulses exactly once after 4 wait cycles, then FETCH re-entered with counter=0.
- opcode 0x3F -> illegal=1:
  - with ILLEGAL_TRAP_EN, stays high and FSM frozen until reset, which clears illegal asynchronously;
  - without it, one-cycle pulse, then FETCH.
